// File: rtl/dcache_nway.sv
// dcache_nway
// Write-back, write-allocate, N-way set-associative data cache. It sits between
// the datapath and the memory controller. It serves read and write hits in the
// same cycle and replaces lines by LRU age. A dirty victim is written back
// before the refill. When the datapath halts, the cache flushes all dirty lines.
//
// Ports
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   dmemREN, dmemWEN     datapath read / write request (write wins)
//   dmemaddr, dmemstore  datapath byte address and write data
//   halt                 datapath halted; starts the flush from IDLE
//   dhit                 request completes this cycle
//   dmemload             read data, valid with dhit && dmemREN
//   flushed              flush finished, held until reset
//   dREN, dWEN           memory read / write request (never both)
//   daddr, dstore        memory word address and write data (0 when idle)
//   dload, dwait         memory read data; a word transfers when dwait is low
module dcache_nway #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);
    localparam int IDXW = $clog2(SETS);
    localparam int OFFW = $clog2(WORDS);
    localparam int AGEW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAGW = 30 - OFFW - IDXW;

    typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, DONE} state_t;
    state_t state;

    // Line storage. Reads are combinational so that a hit completes in the
    // cycle it is requested.
    logic [TAGW-1:0] tagArr   [SETS][WAYS];
    logic [31:0]     dataArr  [SETS][WAYS][WORDS];
    logic [WAYS-1:0] validArr [SETS];
    logic [WAYS-1:0] dirtyArr [SETS];
    logic [AGEW-1:0] ageArr   [SETS][WAYS];

    // Miss context, latched when the miss is taken.
    logic [TAGW-1:0] missTag;
    logic [IDXW-1:0] missIdx;
    logic [AGEW-1:0] victimWay;
    logic [OFFW-1:0] wcnt;

    // Flush scan position.
    logic [IDXW-1:0] flushSet;
    logic [AGEW-1:0] flushWay;

    // Request address decode.
    logic [TAGW-1:0] reqTag;
    logic [IDXW-1:0] reqIdx;
    logic [OFFW-1:0] reqOff;
    logic            unusedBits;

    assign reqTag     = dmemaddr[31:2+OFFW+IDXW];
    assign reqIdx     = dmemaddr[1+OFFW+IDXW:2+OFFW];
    assign reqOff     = dmemaddr[1+OFFW:2];
    assign unusedBits = ^dmemaddr[1:0];

    // Tag compare for every way of the addressed set.
    logic [WAYS-1:0] wayMatch;
    logic            hit;
    logic [AGEW-1:0] hitWay;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
            assign wayMatch[gi] = validArr[reqIdx][gi] && (tagArr[reqIdx][gi] == reqTag);
        end
    endgenerate

    assign hit = |wayMatch;

    always_comb begin
        hitWay = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (wayMatch[i]) hitWay = AGEW'(i);
        end
    end

    // Victim choice. The oldest way is the fallback, and the lowest index wins
    // on an age tie. Any invalid way overrides it. The descending scan makes
    // the lowest invalid index the last assignment.
    logic [AGEW-1:0] victimSel;
    logic [AGEW-1:0] maxAge;

    always_comb begin
        victimSel = '0;
        maxAge    = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (ageArr[reqIdx][i] > maxAge) begin
                maxAge    = ageArr[reqIdx][i];
                victimSel = AGEW'(i);
            end
        end
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!validArr[reqIdx][i]) victimSel = AGEW'(i);
        end
    end

    logic lastWord;
    logic flushDirty;
    logic lastFlushEntry;

    assign lastWord       = (wcnt == OFFW'(WORDS - 1));
    assign flushDirty     = validArr[flushSet][flushWay] && dirtyArr[flushSet][flushWay];
    assign lastFlushEntry = (flushSet == IDXW'(SETS - 1)) && (flushWay == AGEW'(WAYS - 1));

    // Datapath side. The cache answers only in IDLE and only while the
    // datapath is not halting.
    assign dhit     = (state == IDLE) && (dmemREN || dmemWEN) && hit && !halt;
    assign dmemload = ((state == IDLE) && hit) ? dataArr[reqIdx][hitWay][reqOff] : '0;

    // Memory side, decoded from the registered state and counters.
    always_comb begin
        dREN   = 1'b0;
        dWEN   = 1'b0;
        daddr  = '0;
        dstore = '0;
        case (state)
            WB: begin
                dWEN   = 1'b1;
                daddr  = {tagArr[missIdx][victimWay], missIdx, wcnt, 2'b00};
                dstore = dataArr[missIdx][victimWay][wcnt];
            end
            FETCH: begin
                dREN  = 1'b1;
                daddr = {missTag, missIdx, wcnt, 2'b00};
            end
            FLUSH: begin
                if (flushDirty) begin
                    dWEN   = 1'b1;
                    daddr  = {tagArr[flushSet][flushWay], flushSet, wcnt, 2'b00};
                    dstore = dataArr[flushSet][flushWay][wcnt];
                end
            end
            default: ;
        endcase
    end

    // LRU touch. This covers a hit in IDLE, or the fill's last word making the
    // refilled way most recently used.
    logic            lruEn;
    logic [IDXW-1:0] lruIdx;
    logic [AGEW-1:0] lruWay;

    always_comb begin
        lruEn  = 1'b0;
        lruIdx = reqIdx;
        lruWay = hitWay;
        if (dhit) begin
            lruEn = 1'b1;
        end else if ((state == FETCH) && !dwait && lastWord) begin
            lruEn  = 1'b1;
            lruIdx = missIdx;
            lruWay = victimWay;
        end
    end

    // Tag and data arrays have no reset. The valid bits guard them.
    always_ff @(posedge CLK) begin
        if (dhit && dmemWEN) begin
            dataArr[reqIdx][hitWay][reqOff] <= dmemstore;
        end
        if ((state == FETCH) && !dwait) begin
            dataArr[missIdx][victimWay][wcnt] <= dload;
            if (lastWord) begin
                tagArr[missIdx][victimWay] <= missTag;
            end
        end
    end

    // Controller FSM plus the valid, dirty and age state.
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            wcnt      <= '0;
            missTag   <= '0;
            missIdx   <= '0;
            victimWay <= '0;
            flushSet  <= '0;
            flushWay  <= '0;
            flushed   <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                validArr[s] <= '0;
                dirtyArr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    ageArr[s][w] <= '0;
                end
            end
        end else begin
            // Ages younger than the touched way grow older by one. The touched
            // way becomes age 0.
            if (lruEn) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AGEW'(w) == lruWay) begin
                        ageArr[lruIdx][w] <= '0;
                    end else if (ageArr[lruIdx][w] < ageArr[lruIdx][lruWay]) begin
                        ageArr[lruIdx][w] <= ageArr[lruIdx][w] + 1'b1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (halt) begin
                        state    <= FLUSH;
                        wcnt     <= '0;
                        flushSet <= '0;
                        flushWay <= '0;
                    end else if (dmemREN || dmemWEN) begin
                        if (hit) begin
                            if (dmemWEN) dirtyArr[reqIdx][hitWay] <= 1'b1;
                        end else begin
                            missTag   <= reqTag;
                            missIdx   <= reqIdx;
                            victimWay <= victimSel;
                            wcnt      <= '0;
                            if (validArr[reqIdx][victimSel] && dirtyArr[reqIdx][victimSel])
                                state <= WB;
                            else
                                state <= FETCH;
                        end
                    end
                end

                WB: begin
                    if (!dwait) begin
                        // wcnt wraps to 0 after the last word, ready for FETCH.
                        wcnt <= wcnt + 1'b1;
                        if (lastWord) state <= FETCH;
                    end
                end

                FETCH: begin
                    if (!dwait) begin
                        wcnt <= wcnt + 1'b1;
                        if (lastWord) begin
                            validArr[missIdx][victimWay] <= 1'b1;
                            dirtyArr[missIdx][victimWay] <= 1'b0;
                            state                        <= IDLE;
                        end
                    end
                end

                FLUSH: begin
                    if (!flushDirty || (!dwait && lastWord)) begin
                        // The entry is done. Move to the next way, then the next set.
                        wcnt <= '0;
                        if (flushDirty) dirtyArr[flushSet][flushWay] <= 1'b0;
                        if (lastFlushEntry) begin
                            state   <= DONE;
                            flushed <= 1'b1;
                        end else if (flushWay == AGEW'(WAYS - 1)) begin
                            flushWay <= '0;
                            flushSet <= flushSet + 1'b1;
                        end else begin
                            flushWay <= flushWay + 1'b1;
                        end
                    end else if (!dwait) begin
                        wcnt <= wcnt + 1'b1;
                    end
                end

                default: ;  // DONE: parked until reset
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_nway.sv
// tb_dcache_nway
// Directed bench for dcache_nway. A transaction-level cache model predicts,
// for each request, whether it hits, which words go to and from memory, the
// cycle dhit rises and the read data. A per-cycle compare process checks the
// DUT against those expectations. Hand-computed literals pin the model.
`timescale 1ns/1ps
module tb_dcache_nway;
    localparam int SETS  = 8;
    localparam int WAYS  = 2;
    localparam int WORDS = 2;
    localparam int OFFW  = $clog2(WORDS);
    localparam int IDXW  = $clog2(SETS);
    localparam int TAGSH = 2 + OFFW + IDXW;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        dmemREN = 1'b0, dmemWEN = 1'b0, halt = 1'b0, dwait = 1'b0;
    logic [31:0] dmemaddr = '0, dmemstore = '0, dload = '0;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;

    dcache_nway #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS)) dut (
        .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt),
        .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait)
    );

    always #5 CLK = ~CLK;

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory: what the controller holds (mem) and what the model believes it holds (refMem).
    logic [31:0] mem    [1024];
    logic [31:0] refMem [1024];
    int          waitN = 0;
    int          busy  = 0;
    logic [31:0] rdAddrQ[$], wrAddrQ[$], wrDataQ[$];

    // Memory responder. It keeps dwait high for waitN cycles, then transfers one word.
    initial begin
        forever begin
            @(negedge CLK);
            if (dREN || dWEN) begin
                dload = mem[daddr[11:2]];
                if (busy < waitN) begin
                    dwait = 1'b1;
                    busy++;
                end else begin
                    dwait = 1'b0;
                    busy  = 0;
                    if (dWEN) begin
                        mem[daddr[11:2]] = dstore;
                        wrAddrQ.push_back(daddr);
                        wrDataQ.push_back(dstore);
                    end else begin
                        rdAddrQ.push_back(daddr);
                    end
                end
            end else begin
                dwait = 1'b0;
                busy  = 0;
            end
        end
    end

    // Cache model.
    int          mTag   [SETS][WAYS];
    bit          mValid [SETS][WAYS];
    bit          mDirty [SETS][WAYS];
    int          mAge   [SETS][WAYS];
    logic [31:0] mData  [SETS][WAYS][WORDS];
    logic [31:0] expRdA[$], expWbA[$], expWbD[$];

    task automatic modelReset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                mValid[s][w] = 1'b0;
                mDirty[s][w] = 1'b0;
                mAge[s][w]   = 0;
            end
    endtask

    function automatic logic [31:0] mkAddr(input int tag, input int s, input int k);
        return 32'((tag << TAGSH) | (s << (2 + OFFW)) | (k << 2));
    endfunction

    task automatic lruTouch(input int s, input int w);
        int old;
        old = mAge[s][w];
        for (int j = 0; j < WAYS; j++) begin
            if (j == w) mAge[s][j] = 0;
            else if (mAge[s][j] < old) mAge[s][j]++;
        end
    endtask

    // Per-cycle expectations and the compare process.
    bit          checkEn = 1'b0, expDhit = 1'b0, expLoadValid = 1'b0, expFlushed = 1'b0;
    logic [31:0] expLoad = '0, lastLoad = '0;
    bit          prevReq = 1'b0, prevWait = 1'b0;
    logic [31:0] prevAddr = '0;

    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (checkEn) begin
                check("dhit", 32'(dhit), 32'(expDhit));
                if (expLoadValid) begin
                    check("dmemload", dmemload, expLoad);
                    lastLoad = dmemload;
                end
                check("dREN and dWEN together", 32'(dREN && dWEN), 32'd0);
                if (!dREN && !dWEN) check("idle bus", daddr | dstore, 32'd0);
                if (prevReq && prevWait && (dREN || dWEN)) check("daddr stable under dwait", daddr, prevAddr);
                check("flushed", 32'(flushed), 32'(expFlushed));
            end
            prevReq  = dREN || dWEN;
            prevWait = dwait;
            prevAddr = daddr;
        end
    end

    task automatic compareLogs();
        check("read count", 32'(rdAddrQ.size()), 32'(expRdA.size()));
        foreach (expRdA[i]) check("read addr", (i < rdAddrQ.size()) ? rdAddrQ[i] : 32'hFFFF_FFFF, expRdA[i]);
        check("write count", 32'(wrAddrQ.size()), 32'(expWbA.size()));
        foreach (expWbA[i]) begin
            check("write addr", (i < wrAddrQ.size()) ? wrAddrQ[i] : 32'hFFFF_FFFF, expWbA[i]);
            check("write data", (i < wrDataQ.size()) ? wrDataQ[i] : 32'hFFFF_FFFF, expWbD[i]);
        end
    endtask

    // One datapath request. Call it at posedge+1 with the cache idle.
    task automatic doReq(input bit ren, input bit wen, input logic [31:0] addr, input logic [31:0] wdata);
        int unsigned ua;
        int s, tag, k, hw, v, nWords, L;
        logic [31:0] a;
        ua  = addr;
        s   = int'((ua >> (2 + OFFW)) % SETS);
        tag = int'(ua >> TAGSH);
        k   = int'((ua >> 2) % WORDS);
        expRdA.delete(); expWbA.delete(); expWbD.delete();
        hw = -1;
        for (int w = 0; w < WAYS; w++) if (mValid[s][w] && mTag[s][w] == tag) hw = w;
        L = 0;
        if (hw < 0) begin
            v = -1;
            for (int w = 0; w < WAYS; w++) if (!mValid[s][w] && v < 0) v = w;
            if (v < 0) begin
                v = 0;
                for (int w = 0; w < WAYS; w++) if (mAge[s][w] > mAge[s][v]) v = w;
            end
            nWords = WORDS;
            if (mValid[s][v] && mDirty[s][v]) begin
                for (int kk = 0; kk < WORDS; kk++) begin
                    a = mkAddr(mTag[s][v], s, kk);
                    expWbA.push_back(a);
                    expWbD.push_back(mData[s][v][kk]);
                    refMem[a[11:2]] = mData[s][v][kk];
                end
                nWords += WORDS;
            end
            for (int kk = 0; kk < WORDS; kk++) begin
                a = mkAddr(tag, s, kk);
                expRdA.push_back(a);
                mData[s][v][kk] = refMem[a[11:2]];
            end
            mTag[s][v]   = tag;
            mValid[s][v] = 1'b1;
            mDirty[s][v] = 1'b0;
            lruTouch(s, v);
            L  = nWords * (waitN + 1) + 1;
            hw = v;
        end
        expLoad = mData[s][hw][k];
        lruTouch(s, hw);
        if (wen) begin
            mData[s][hw][k] = wdata;
            mDirty[s][hw]   = 1'b1;
        end

        rdAddrQ.delete(); wrAddrQ.delete(); wrDataQ.delete();
        dmemREN = ren; dmemWEN = wen; dmemaddr = addr; dmemstore = wdata;
        for (int c = 0; c <= L; c++) begin
            expDhit      = (c == L);
            expLoadValid = (c == L) && ren && !wen;
            @(posedge CLK);
            #1;
        end
        dmemREN = 1'b0; dmemWEN = 1'b0; expDhit = 1'b0; expLoadValid = 1'b0;
        compareLogs();
        $display("req %s addr 0x%08h: %s, dhit after %0d cycles", wen ? "WR" : "RD", addr, (L == 0) ? "hit" : "miss", L);
    endtask

    // Halt-time flush, then check that the cache stays parked in DONE.
    task automatic doFlush();
        int cyc;
        logic [31:0] a;
        cyc = 0;
        expRdA.delete(); expWbA.delete(); expWbD.delete();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                if (mValid[s][w] && mDirty[s][w]) begin
                    for (int kk = 0; kk < WORDS; kk++) begin
                        a = mkAddr(mTag[s][w], s, kk);
                        expWbA.push_back(a);
                        expWbD.push_back(mData[s][w][kk]);
                        refMem[a[11:2]] = mData[s][w][kk];
                    end
                    mDirty[s][w] = 1'b0;
                    cyc += WORDS * (waitN + 1);
                end else begin
                    cyc += 1;
                end
            end
        rdAddrQ.delete(); wrAddrQ.delete(); wrDataQ.delete();
        halt = 1'b1;
        // One edge leaves IDLE, then one edge per scan cycle.
        for (int c = 0; c <= cyc; c++) begin
            @(posedge CLK);
            #1;
        end
        expFlushed = 1'b1;
        compareLogs();
        $display("flush: %0d write-backs, %0d scan cycles", expWbA.size(), cyc);
        check("flush wb0 addr", (wrAddrQ.size() > 0) ? wrAddrQ[0] : 32'hFFFF_FFFF, 32'h0000_0048);
        check("flush wb2 addr", (wrAddrQ.size() > 2) ? wrAddrQ[2] : 32'hFFFF_FFFF, 32'h0000_0058);
        check("flush wb3 data", (wrDataQ.size() > 3) ? wrDataQ[3] : 32'hFFFF_FFFF, 32'h3333_3333);

        // A request to a line that is still valid gets no dhit after the flush.
        halt = 1'b0;
        rdAddrQ.delete(); wrAddrQ.delete(); wrDataQ.delete();
        dmemREN = 1'b1; dmemaddr = 32'h200;
        repeat (4) begin
            @(posedge CLK);
            #1;
        end
        dmemREN = 1'b0;
        check("done memory idle", 32'(rdAddrQ.size() + wrAddrQ.size()), 32'd0);
        $display("done: request ignored, flushed held");
    endtask

    // Assert reset while the second fill word is on the bus.
    task automatic doResetMidFetch();
        dmemREN = 1'b1; dmemaddr = 32'h200;
        @(posedge CLK); #1;              // FETCH word 0
        @(posedge CLK); #1;              // FETCH word 1
        checkEn = 1'b0;
        check("mid-fetch dREN", 32'(dREN), 32'd1);
        check("mid-fetch daddr", daddr, 32'h0000_0204);
        nRST = 1'b0;
        #1;
        check("reset dREN", 32'(dREN), 32'd0);
        check("reset daddr", daddr, 32'd0);
        check("reset dhit", 32'(dhit), 32'd0);
        dmemREN = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        modelReset();
        @(posedge CLK); #1;
        checkEn = 1'b1;
        $display("reset asserted during fill word 1 of 0x200");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = 32'hA500_0000 ^ (i * 4);
            refMem[i] = mem[i];
        end
        modelReset();

        #1 nRST = 1'b0;
        #2;
        check("reset dhit", 32'(dhit), 32'd0);
        check("reset dmemload", dmemload, 32'd0);
        check("reset flushed", 32'(flushed), 32'd0);
        check("reset dREN/dWEN", {30'd0, dREN, dWEN}, 32'd0);
        check("reset daddr", daddr, 32'd0);
        check("reset dstore", dstore, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;
        checkEn = 1'b1;

        // Cold read, then a same-line hit.
        doReq(1'b1, 1'b0, 32'h40, 32'h0);
        check("t1 cold load", lastLoad, 32'hA500_0040);
        check("t1 fetch word1 addr", (rdAddrQ.size() > 1) ? rdAddrQ[1] : 32'hFFFF_FFFF, 32'h0000_0044);
        doReq(1'b1, 1'b0, 32'h44, 32'h0);
        check("t1 hit load", lastLoad, 32'hA500_0044);

        // Write hit, then reread.
        doReq(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
        doReq(1'b1, 1'b0, 32'h40, 32'h0);
        check("t2 reread", lastLoad, 32'hDEAD_BEEF);

        // Fill set 0, then force out the dirty LRU line.
        doReq(1'b1, 1'b0, 32'h80, 32'h0);
        doReq(1'b1, 1'b0, 32'hC0, 32'h0);
        check("t3 wb0 addr", (wrAddrQ.size() > 0) ? wrAddrQ[0] : 32'hFFFF_FFFF, 32'h0000_0040);
        check("t3 wb0 data", (wrDataQ.size() > 0) ? wrDataQ[0] : 32'hFFFF_FFFF, 32'hDEAD_BEEF);
        check("t3 wb1 addr", (wrAddrQ.size() > 1) ? wrAddrQ[1] : 32'hFFFF_FFFF, 32'h0000_0044);
        check("t3 load", lastLoad, 32'hA500_00C0);

        // Slow memory.
        waitN = 5;
        doReq(1'b1, 1'b0, 32'h100, 32'h0);
        check("t4 load", lastLoad, 32'hA500_0100);
        waitN = 0;
        doReq(1'b1, 1'b0, 32'h104, 32'h0);
        check("t4 hit load", lastLoad, 32'hA500_0104);

        // Reset mid-fill, then the same read misses again.
        doResetMidFetch();
        doReq(1'b1, 1'b0, 32'h200, 32'h0);
        check("t6 refetch addr", (rdAddrQ.size() > 0) ? rdAddrQ[0] : 32'hFFFF_FFFF, 32'h0000_0200);
        check("t6 load", lastLoad, 32'hA500_0200);

        // Dirty lines in sets 1 and 3, then flush.
        doReq(1'b0, 1'b1, 32'h48, 32'h1111_1111);
        doReq(1'b0, 1'b1, 32'h5C, 32'h3333_3333);
        doFlush();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
